// File: rtl/pp_pipeline_accel_udiv_27ns_11ns_16_seq.sv
// Sequential restoring unsigned divider: one quotient bit per enabled cycle,
// with valid/ready handshakes on both sides and divide-by-zero/overflow shortcuts.
module pp_pipeline_accel_udiv_27ns_11ns_16_seq #(
    parameter int DIVIDEND_WIDTH = 27,
    parameter int DIVISOR_WIDTH  = 11,
    parameter int QUOTIENT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      dbz,
    output logic                      ovf
);

    localparam int CW = (QUOTIENT_WIDTH > 1) ? $clog2(QUOTIENT_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic                       armed_r;
    logic                       in_xfer_s;
    logic                       out_xfer_s;
    logic                       zero_div_s;
    logic                       too_big_s;
    logic [DIVISOR_WIDTH-1:0]   dvd_hi_s;
    logic [DIVISOR_WIDTH-1:0]   dsr_r;
    logic [DIVISOR_WIDTH-1:0]   rem_r;
    logic [QUOTIENT_WIDTH-1:0]  sr_r;
    logic [CW-1:0]              cnt_r;
    logic                       dbz_r;
    logic                       ovf_r;
    logic [DIVISOR_WIDTH:0]     trial_s;
    logic [DIVISOR_WIDTH:0]     diff_s;
    logic                       ge_s;
    logic                       out_valid_r;
    logic [QUOTIENT_WIDTH-1:0]  quotient_r;
    logic [DIVISOR_WIDTH-1:0]   remainder_r;
    logic                       dbz_out_r;
    logic                       ovf_out_r;

    assign dvd_hi_s   = dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
    assign zero_div_s = (divisor == {DIVISOR_WIDTH{1'b0}});
    assign too_big_s  = (dvd_hi_s >= divisor);
    // armed_r keeps in_ready low until the first enabled edge after reset
    assign in_ready   = ce & armed_r & (state_r == IDLE);
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid_r & out_ready & ce;

    // sr_r shifts dividend bits out of its MSB while quotient bits enter at the LSB
    assign trial_s = {rem_r, sr_r[QUOTIENT_WIDTH-1]};
    assign diff_s  = trial_s - {1'b0, dsr_r};
    assign ge_s    = (trial_s >= {1'b0, dsr_r});

    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign dbz       = dbz_out_r;
    assign ovf       = ovf_out_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            armed_r <= 1'b0;
        end else if (ce) begin
            state_r <= state_s;
            armed_r <= 1'b1;
        end else begin
            state_r <= state_r;
            armed_r <= armed_r;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_xfer_s) begin
                    if (zero_div_s || too_big_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(QUOTIENT_WIDTH - 1)) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_xfer_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture and restoring-division datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsr_r <= {DIVISOR_WIDTH{1'b0}};
            rem_r <= {DIVISOR_WIDTH{1'b0}};
            sr_r  <= {QUOTIENT_WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (ce) begin
            case (state_r)
                IDLE: begin
                    if (in_xfer_s) begin
                        dsr_r <= divisor;
                        cnt_r <= {CW{1'b0}};
                        if (zero_div_s) begin
                            rem_r <= {DIVISOR_WIDTH{1'b0}};
                            sr_r  <= {QUOTIENT_WIDTH{1'b1}};
                            dbz_r <= 1'b1;
                            ovf_r <= 1'b0;
                        end else if (too_big_s) begin
                            rem_r <= {DIVISOR_WIDTH{1'b0}};
                            sr_r  <= {QUOTIENT_WIDTH{1'b1}};
                            dbz_r <= 1'b0;
                            ovf_r <= 1'b1;
                        end else begin
                            rem_r <= dvd_hi_s;
                            sr_r  <= dividend[QUOTIENT_WIDTH-1:0];
                            dbz_r <= 1'b0;
                            ovf_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r <= ge_s ? diff_s[DIVISOR_WIDTH-1:0] : trial_s[DIVISOR_WIDTH-1:0];
                    sr_r  <= {sr_r[QUOTIENT_WIDTH-2:0], ge_s};
                    cnt_r <= cnt_r + CW'(1);
                end
                default: begin
                    rem_r <= rem_r;
                    sr_r  <= sr_r;
                end
            endcase
        end
    end

    // Result registers: loaded one cycle into DONE, zero whenever out_valid is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            quotient_r  <= {QUOTIENT_WIDTH{1'b0}};
            remainder_r <= {DIVISOR_WIDTH{1'b0}};
            dbz_out_r   <= 1'b0;
            ovf_out_r   <= 1'b0;
        end else if (ce) begin
            if (out_xfer_s || (state_r != DONE)) begin
                out_valid_r <= 1'b0;
                quotient_r  <= {QUOTIENT_WIDTH{1'b0}};
                remainder_r <= {DIVISOR_WIDTH{1'b0}};
                dbz_out_r   <= 1'b0;
                ovf_out_r   <= 1'b0;
            end else begin
                out_valid_r <= 1'b1;
                quotient_r  <= sr_r;
                remainder_r <= rem_r;
                dbz_out_r   <= dbz_r;
                ovf_out_r   <= ovf_r;
            end
        end
    end

endmodule
